// File: rtl/sseg_pkg.sv
// Shared types and constants for the display message scheduler.
package sseg_pkg;

   typedef logic [4:0] glyph_t;

   // Non-hex glyphs understood by the segment driver
   localparam glyph_t GL_BLANK = 5'h10;
   localparam glyph_t GL_B     = 5'h11;
   localparam glyph_t GL_T     = 5'h12;
   localparam glyph_t GL_E     = 5'h13;
   localparam glyph_t GL_R     = 5'h14;
   localparam glyph_t GL_DASH  = 5'h15;

   typedef enum logic [1:0] {
      SRC_VAL = 2'd0,
      SRC_BT  = 2'd1,
      SRC_ERR = 2'd2
   } src_t;

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StDone
   } conv_state_t;

   localparam int unsigned BIN_W = 11;
   localparam int unsigned BCD_W = 16;

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] r;
      r = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 11-bit binary to four BCD digits, one step per cycle.
module bin2bcd_seq
   import sseg_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             idle,
   output logic [BCD_W-1:0] bcd,
   output logic [BCD_W-1:0] bcd_shift
);

   localparam int unsigned SH_W = BCD_W + BIN_W;

   conv_state_t      state_q;
   logic [SH_W-1:0]  shift_q;
   logic [3:0]       step_q;
   logic [BCD_W-1:0] bcd_q;
   logic             busy_q;
   logic             done_q;
   logic [BCD_W-1:0] adj;

   // Corrected BCD part of the shift register before this cycle's shift
   always_comb begin
      adj = dd_adjust(shift_q[SH_W-1 -: BCD_W]);
   end

   // Conversion FSM: capture, 11 shift-add-3 steps, then publish the result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         step_q  <= '0;
         bcd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  shift_q <= {{BCD_W{1'b0}}, bin};
                  step_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StConv;
               end
            end
            StConv: begin
               shift_q <= {adj, shift_q[BIN_W-1:0]} << 1;
               step_q  <= step_q + 4'd1;
               if (step_q == 4'(BIN_W - 1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               bcd_q   <= shift_q[SH_W-1 -: BCD_W];
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign idle      = (state_q == StIdle);
   assign bcd       = bcd_q;
   // Final digits are already in the shift register during the done cycle
   assign bcd_shift = shift_q[SH_W-1 -: BCD_W];

endmodule

// File: rtl/sseg_msg_sched.sv
// Display message scheduler: arbitrates ERR > BT > VAL and emits registered glyphs.
module sseg_msg_sched
   import sseg_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned HOLD_MS = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] x_val,
   input  logic        x_valid,
   input  logic        bt_req,
   input  logic        err_req,
   input  logic [3:0]  err_code,
   output logic [19:0] digits,
   output logic        digits_upd,
   output logic [1:0]  src,
   output logic        busy
);

   localparam int unsigned DIV_CYC = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
   localparam int unsigned DIV_W   = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
   localparam int unsigned HOLD_W  = $clog2(HOLD_MS + 1);
   localparam logic [19:0] RST_DIGITS = {GL_BLANK, GL_BLANK, GL_BLANK, 5'h00};

   logic [DIV_W-1:0]  div_q, div_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        code_q, code_d;
   logic              tick;
   logic              pend_q;
   logic [BIN_W-1:0]  pend_val_q;
   logic              conv_start, conv_busy, conv_done, conv_idle;
   logic [BIN_W-1:0]  conv_bin;
   logic [BCD_W-1:0]  bcd_res, bcd_shift, val_bcd;
   logic [19:0]       val_glyphs;
   logic [19:0]       digits_q, digits_d;
   logic              upd_q;
   src_t              src_q, src_d;

   // A fresh value wins over the pending one when both are present at start
   assign conv_start = x_valid | pend_q;
   assign conv_bin   = x_valid ? x_val : pend_val_q;

   bin2bcd_seq u_conv (
      .clk       (clk),
      .rst       (rst),
      .start     (conv_start),
      .bin       (conv_bin),
      .busy      (conv_busy),
      .done      (conv_done),
      .idle      (conv_idle),
      .bcd       (bcd_res),
      .bcd_shift (bcd_shift)
   );

   // Millisecond divider and error hold countdown; err_req restarts both
   always_comb begin
      tick   = (div_q == DIV_W'(DIV_CYC - 1));
      div_d  = tick ? '0 : div_q + DIV_W'(1);
      hold_d = hold_q;
      code_d = code_q;
      if (tick && hold_q != '0) begin
         hold_d = hold_q - HOLD_W'(1);
      end
      if (err_req) begin
         div_d  = '0;
         hold_d = HOLD_W'(HOLD_MS);
         code_d = err_code;
      end
   end

   // Source and glyphs are chosen from next-state so the display follows inputs by one cycle
   always_comb begin
      if (hold_d != '0) begin
         src_d = SRC_ERR;
      end else if (bt_req) begin
         src_d = SRC_BT;
      end else begin
         src_d = SRC_VAL;
      end
   end

   // Decimal value with leading-zero blanking; units digit always visible
   always_comb begin
      val_bcd          = conv_done ? bcd_shift : bcd_res;
      val_glyphs       = '0;
      val_glyphs[4:0]  = {1'b0, val_bcd[3:0]};
      val_glyphs[9:5]  = (val_bcd[15:4] == '0) ? GL_BLANK : {1'b0, val_bcd[7:4]};
      val_glyphs[14:10] = (val_bcd[15:8] == '0) ? GL_BLANK : {1'b0, val_bcd[11:8]};
      val_glyphs[19:15] = (val_bcd[15:12] == '0) ? GL_BLANK : {1'b0, val_bcd[15:12]};
   end

   // Priority mux of the three messages
   always_comb begin
      digits_d = val_glyphs;
      unique case (src_d)
         SRC_ERR: digits_d = {GL_E, GL_R, GL_R, 1'b0, code_d};
         SRC_BT:  digits_d = {GL_DASH, GL_B, GL_T, GL_DASH};
         default: digits_d = val_glyphs;
      endcase
   end

   // Latest x_val arriving while the converter is occupied waits here
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q     <= 1'b0;
         pend_val_q <= '0;
      end else if (x_valid && !conv_idle) begin
         pend_q     <= 1'b1;
         pend_val_q <= x_val;
      end else if (conv_idle) begin
         pend_q     <= 1'b0;
      end
   end

   // Timer state, latched error code and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q    <= '0;
         hold_q   <= '0;
         code_q   <= '0;
         digits_q <= RST_DIGITS;
         upd_q    <= 1'b0;
         src_q    <= SRC_VAL;
      end else begin
         div_q    <= div_d;
         hold_q   <= hold_d;
         code_q   <= code_d;
         digits_q <= digits_d;
         upd_q    <= (digits_d != digits_q);
         src_q    <= src_d;
      end
   end

   assign digits     = digits_q;
   assign digits_upd = upd_q;
   assign src        = src_q;
   assign busy       = conv_busy;

endmodule

// File: doc/sseg_msg_sched.md
# sseg_msg_sched

Display message scheduler that sits upstream of the 7-segment controller and decides what the 4-digit display shows. It shares the display between three requesters: the servo position value, the backtrack status and one-shot error events. It converts the 11-bit position to decimal with a sequential converter and enforces a timed hold for error messages. It outputs four registered glyph codes plus an update strobe; the segment driver decodes the glyphs and multiplexes the anodes.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- HOLD_MS, 1000, error message hold time in milliseconds (≥1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- x_val  in  11  servo position, unsigned 0..2047
- x_valid  in  1  single-cycle strobe: x_val is new
- bt_req  in  1  level: backtrack active
- err_req  in  1  single-cycle strobe: error event
- err_code  in  4  error code, sampled with err_req
- digits  out  20  four 5-bit glyph codes, [19:15]=leftmost digit
- digits_upd  out  1  single-cycle pulse when digits changes
- src  out  2  current source: 0=VAL, 1=BT, 2=ERR
- busy  out  1  decimal conversion in progress

## Operation
- Glyph codes:
  - 0x00–0x0F are hex digits 0–F.
  - 0x10 is blank, 0x11 is 'b', 0x12 is 't', 0x13 is 'E', 0x14 is 'r', 0x15 is '-'.
- Priority is ERR > BT > VAL, re-evaluated every cycle.
  - ERR is active while the hold counter is non-zero.
  - BT is active while bt_req=1.
  - Otherwise the source is VAL.
- ERR message is "E r r h", where h = the latched err_code.
  - err_req loads hold = HOLD_MS, latches err_code and clears the ms divider.
  - A new err_req during a hold restarts the hold and replaces the code.
- BT message is "- b t -".
- VAL message is the decimal value of the last converted x_val.
  - Leading zeros are blanked; the units digit is always shown.
  - Example: 7 → "   7"; 2047 → "2047"; 0 → "   0".
- Conversion FSM states: IDLE, CONV, DONE.
  - IDLE→CONV when x_valid=1 or pend=1. The capture register takes x_val (or the pending value); pend is cleared.
  - CONV performs 11 shift-add-3 steps (one per cycle), then goes to DONE.
  - DONE writes the BCD result register, then returns to IDLE.
  - x_valid while not IDLE stores x_val in the pending register and sets pend=1. Only the latest value is kept; earlier pending values are dropped.
- The BCD result updates in the background regardless of src. On return to VAL the display shows the latest result.
- digits is a register. digits_upd=1 exactly on cycles where the newly registered digits differ from the previous value.
- Simultaneous events:
  - err_req and x_valid in the same cycle are both accepted.
  - bt_req falling during an ERR hold leaves ERR showing; at hold expiry the source goes straight to VAL.

## Timing
- ms tick: the divider counts 0..CLK_HZ/1000−1 and ticks on wrap. hold decrements on each tick.
- ERR lasts exactly HOLD_MS·CLK_HZ/1000 cycles from the cycle after err_req.
- Conversion latency:
  - x_valid sampled at cycle N.
  - busy=1 on cycles N+1..N+11.
  - Result register written at the end of N+12.
  - If src=VAL, digits changes and digits_upd pulses at N+13.
- Source change (bt_req edge, err_req, hold expiry): digits changes 1 cycle after the input edge is sampled.
- Reset values:
  - digits = {0x10,0x10,0x10,0x00}, i.e. "   0".
  - src=0, busy=0, digits_upd=0.
  - hold=0, divider=0, pend=0, FSM=IDLE, result=0.
- Reset mid-conversion aborts: the pending value and the partial result are discarded.

## Structure
- Package sseg_pkg holds:
  - glyph localparams (GL_BLANK, GL_B, GL_T, GL_E, GL_R, GL_DASH)
  - src_t enum {SRC_VAL, SRC_BT, SRC_ERR}
  - typedef glyph_t (logic [4:0])
- Sub-module bin2bcd_seq: sequential double-dabble, 11-bit in → four 4-bit BCD digits, with start/busy/done ports. It contains the CONV shift register.
- The top level contains the hold/divider, pending register, priority mux, blanking logic and output register.

## Test plan
Simulate with CLK_HZ=10_000, HOLD_MS=3, giving 10 cycles/ms and a 30-cycle hold.
- Release reset with all inputs low → digits="   0" (0x10,0x10,0x10,0x00), src=0, no digits_upd.
- x_valid with x_val=2047 at cycle N → busy on N+1..N+11; digits=2,0,4,7 and a one-cycle digits_upd at N+13. Repeat with x_val=7 → "   7".
- x_valid with 100, then x_valid with 5 and then 9 during busy → digits shows "100", then "   9"; 5 never appears.
- bt_req=1 → "- b t -" next cycle, src=1. err_req with code 0xA → "E r r A", src=2. Drop bt_req mid-hold → ERR persists 30 cycles from err_req, then the last value shows with src=0.
- err_req code 3, then err_req code 5 after 20 cycles → ERR "Err5" lasts 30 cycles from the second strobe.
- Assert rst at cycle 5 of a conversion → outputs return to reset values; no late update after reset.
